// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu shared definitions: funct3 codes, widths,
// FSM states and fault causes.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;

  localparam logic [1:0] C_NONE     = 2'b00;
  localparam logic [1:0] C_MISALIGN = 2'b01;
  localparam logic [1:0] C_RANGE    = 2'b10;
  localparam logic [1:0] C_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  function automatic logic [2:0] width_bytes(
    input logic [1:0] width
  );
    unique case (width)
      W_BYTE:  width_bytes = 3'd1;
      W_HALF:  width_bytes = 3'd2;
      default: width_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_check.sv
// dmem_lsu request decode and fault classification.
// Purely combinational; addr[32] flags an out-of-space EA.
module dmem_lsu_check
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4021
) (
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [32:0] addr,
  output logic [1:0]  width,
  output logic        signext,
  output logic        fault,
  output logic [1:0]  cause
);

  logic        illegal;
  logic        misalign;
  logic        range;
  logic [33:0] last;

  always_comb begin
    unique case (funct3[1:0])
      2'b00:   width = W_BYTE;
      2'b01:   width = W_HALF;
      default: width = W_WORD;
    endcase
    signext = ~funct3[2];
  end

  always_comb begin
    if (store)
      illegal = funct3[2];
    else
      illegal = (funct3 == 3'b011) ||
                (funct3[2:1] == 2'b11);
  end

  always_comb begin
    misalign = 1'b0;
    if (width == W_HALF)
      misalign = addr[0];
    else if (width == W_WORD)
      misalign = |addr[1:0];
  end

  // Last touched byte, wide enough that no carry is lost.
  assign last  = {1'b0, addr} +
                 {31'b0, width_bytes(width)} - 34'd1;
  assign range = last >= 34'(MEM_BYTES);

  always_comb begin
    fault = 1'b1;
    if (illegal)
      cause = C_ILLEGAL;
    else if (misalign)
      cause = C_MISALIGN;
    else if (range)
      cause = C_RANGE;
    else begin
      cause = C_NONE;
      fault = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving the data memory
// strobe interface, one request in flight at a time.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4021
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] data_addr,
  output logic [1:0]  data_width,
  output logic        data_i,
  output logic        data_o,
  output logic        signext,
  output logic [31:0] input_data,
  input  logic [31:0] read,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [1:0]  resp_cause
);

  state_t      state;
  logic [33:0] ea_sum;
  logic        ea_wrap;
  logic [1:0]  c_width;
  logic        c_signext;
  logic        c_fault;
  logic [1:0]  c_cause;

  // Signed sum: any result outside 0..2^32-1 is a wrap.
  assign ea_sum  = {2'b00, req_base} +
                   {{2{req_offset[31]}}, req_offset};
  assign ea_wrap = ea_sum[33] | ea_sum[32];

  dmem_lsu_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .funct3  (req_funct3),
    .store   (req_store),
    .addr    ({ea_wrap, ea_sum[31:0]}),
    .width   (c_width),
    .signext (c_signext),
    .fault   (c_fault),
    .cause   (c_cause)
  );

  assign req_ready = (state == IDLE);
  assign resp_data = (state == RESP) ? read : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      data_addr  <= '0;
      data_width <= W_WORD;
      signext    <= 1'b0;
      input_data <= '0;
      resp_rd    <= '0;
      data_i     <= 1'b0;
      data_o     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_cause <= C_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state      <= ISSUE;
            data_addr  <= ea_sum[31:0];
            data_width <= c_width;
            signext    <= c_signext;
            input_data <= req_wdata;
            resp_rd    <= req_rd;
            data_i     <= req_store & ~c_fault;
            data_o     <= ~req_store & ~c_fault;
            resp_valid <= req_store | c_fault;
            resp_err   <= c_fault;
            resp_cause <= c_cause;
          end
        end
        ISSUE: begin
          data_i     <= 1'b0;
          data_o     <= 1'b0;
          resp_err   <= 1'b0;
          resp_cause <= C_NONE;
          if (data_o) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small byte memory
// that registers sign/zero-extended reads.
module tb_dmem_lsu;

  localparam int MEM = 4021;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] data_addr;
  logic [1:0]  data_width;
  logic        data_i;
  logic        data_o;
  logic        signext;
  logic [31:0] input_data;
  logic [31:0] read;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic [1:0]  resp_cause;

  logic [7:0]  mem [MEM];
  int          n_cmp = 0;
  int          n_bad = 0;

  dmem_lsu #(.MEM_BYTES(MEM)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .data_addr  (data_addr),
    .data_width (data_width),
    .data_i     (data_i),
    .data_o     (data_o),
    .signext    (signext),
    .input_data (input_data),
    .read       (read),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err),
    .resp_cause (resp_cause)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    int nb;
    logic [31:0] v;
    nb = (data_width == 2'b10) ? 1 :
         (data_width == 2'b01) ? 2 : 4;
    if (data_i) begin
      for (int k = 0; k < nb; k++)
        if (data_addr + k < MEM)
          mem[data_addr + k] = input_data[8*k +: 8];
    end
    if (data_o) begin
      v = '0;
      for (int k = 0; k < nb; k++)
        if (data_addr + k < MEM)
          v[8*k +: 8] = mem[data_addr + k];
      if (signext && nb == 1) v[31:8]  = {24{v[7]}};
      if (signext && nb == 2) v[31:16] = {16{v[15]}};
      read <= v;
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge
  // of the cycle after acceptance (cycle N+1).
  task automatic send(
    input logic        st,
    input logic [2:0]  f3,
    input logic [31:0] b,
    input logic [31:0] o,
    input logic [31:0] w,
    input logic [4:0]  rd
  );
    req_store  = st;
    req_funct3 = f3;
    req_base   = b;
    req_offset = o;
    req_wdata  = w;
    req_rd     = rd;
    req_valid  = 1'b1;
    check("ready_pre", 32'(req_ready), 32'd1);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic fault(
    input string       tag,
    input logic        st,
    input logic [2:0]  f3,
    input logic [31:0] b,
    input logic [31:0] o,
    input logic [1:0]  cause
  );
    send(st, f3, b, o, 32'h1234_5678, 5'd9);
    check({tag, "_vld"}, 32'(resp_valid), 32'd1);
    check({tag, "_err"}, 32'(resp_err), 32'd1);
    check({tag, "_cause"}, 32'(resp_cause), 32'(cause));
    check({tag, "_stb"}, {30'd0, data_i, data_o}, 32'd0);
    check({tag, "_data"}, resp_data, 32'd0);
    @(negedge CLK);
    check({tag, "_vld2"}, 32'(resp_valid), 32'd0);
    check({tag, "_stb2"}, {30'd0, data_i, data_o}, 32'd0);
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
  endtask

  task automatic load(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] b,
    input logic [31:0] o,
    input logic [4:0]  rd,
    input logic [1:0]  w,
    input logic        sx,
    input logic [31:0] exp
  );
    send(1'b0, f3, b, o, 32'd0, rd);
    check({tag, "_ld_o"}, 32'(data_o), 32'd1);
    check({tag, "_st_i"}, 32'(data_i), 32'd0);
    check({tag, "_width"}, 32'(data_width), 32'(w));
    check({tag, "_sx"}, 32'(signext), 32'(sx));
    check({tag, "_vld1"}, 32'(resp_valid), 32'd0);
    @(negedge CLK);
    check({tag, "_ld_o2"}, 32'(data_o), 32'd0);
    check({tag, "_vld"}, 32'(resp_valid), 32'd1);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
    check({tag, "_data"}, resp_data, exp);
    check({tag, "_rd"}, 32'(resp_rd), 32'(rd));
    check({tag, "_busy"}, 32'(req_ready), 32'd0);
    @(negedge CLK);
    check({tag, "_vld3"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation budget expired");
    $fatal(1);
  end

  initial begin
    int acc;
    int stb;
    for (int i = 0; i < MEM; i++) mem[i] = 8'h00;
    read       = '0;
    RST_N      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = '0;
    req_base   = '0;
    req_offset = '0;
    req_wdata  = '0;
    req_rd     = '0;
    #3;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_stb", {30'd0, data_i, data_o}, 32'd0);
    check("rst_vld", 32'(resp_valid), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_cause", 32'(resp_cause), 32'd0);
    check("rst_addr", data_addr, 32'd0);
    check("rst_wd", input_data, 32'd0);
    check("rst_rdata", resp_data, 32'd0);
    check("rst_rd", 32'(resp_rd), 32'd0);
    check("rst_width", 32'(data_width), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    send(1'b1, 3'b010, 32'h100, 32'd4, 32'hDEAD_BEEF, 5'd3);
    check("sw_st_i", 32'(data_i), 32'd1);
    check("sw_ld_o", 32'(data_o), 32'd0);
    check("sw_addr", data_addr, 32'h104);
    check("sw_width", 32'(data_width), 32'd0);
    check("sw_wd", input_data, 32'hDEAD_BEEF);
    check("sw_vld", 32'(resp_valid), 32'd1);
    check("sw_err", 32'(resp_err), 32'd0);
    check("sw_data", resp_data, 32'd0);
    check("sw_busy", 32'(req_ready), 32'd0);
    @(negedge CLK);
    check("sw_st_i2", 32'(data_i), 32'd0);
    check("sw_vld2", 32'(resp_valid), 32'd0);
    check("sw_rdy", 32'(req_ready), 32'd1);

    load("lb", 3'b000, 32'h100, 32'd4, 5'd7,
         2'b10, 1'b1, 32'hFFFF_FFEF);
    load("lbu", 3'b100, 32'h108, 32'hFFFF_FFFC, 5'd8,
         2'b10, 1'b0, 32'h0000_00EF);
    load("lh", 3'b001, 32'h104, 32'd0, 5'd10,
         2'b01, 1'b1, 32'hFFFF_BEEF);
    load("lhu", 3'b101, 32'h106, 32'd0, 5'd11,
         2'b01, 1'b0, 32'h0000_DEAD);
    load("lw", 3'b010, 32'h104, 32'd0, 5'd31,
         2'b00, 1'b1, 32'hDEAD_BEEF);

    fault("lh_mis", 1'b0, 3'b001, 32'h100, 32'd3, 2'b01);
    fault("sw_mis", 1'b1, 3'b010, 32'h102, 32'd0, 2'b01);
    fault("lw_rng", 1'b0, 3'b010, 32'd0, 32'd4020, 2'b10);
    fault("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FFFC,
          32'd8, 2'b10);
    fault("lh_neg", 1'b0, 3'b001, 32'd0,
          32'hFFFF_FFFE, 2'b10);
    fault("ld_ill", 1'b0, 3'b011, 32'h100, 32'd0, 2'b11);
    fault("st_ill", 1'b1, 3'b100, 32'h100, 32'd0, 2'b11);
    fault("ill_mis", 1'b0, 3'b110, 32'h101, 32'd0, 2'b11);

    send(1'b1, 3'b000, 32'd4000, 32'd20, 32'h0000_0080, 5'd1);
    check("sb_edge_st", 32'(data_i), 32'd1);
    check("sb_edge_err", 32'(resp_err), 32'd0);
    @(negedge CLK);
    load("lb_edge", 3'b000, 32'd4020, 32'd0, 5'd2,
         2'b10, 1'b1, 32'hFFFF_FF80);

    // Hold req_valid for six cycles of back-to-back stores.
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_base   = 32'h200;
    req_offset = 32'd0;
    req_wdata  = 32'h0BAD_F00D;
    req_rd     = 5'd4;
    req_valid  = 1'b1;
    acc = 0;
    stb = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_ready) acc++;
      @(negedge CLK);
      if (data_i) stb++;
      if (data_i && req_ready) stb += 100;
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd3);
    check("b2b_strobes", 32'(stb), 32'd3);
    check("b2b_rdy", 32'(req_ready), 32'd1);

    send(1'b0, 3'b010, 32'h104, 32'd0, 32'd0, 5'd5);
    check("rst_mid_ld_o", 32'(data_o), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    check("rst_mid_drop", 32'(data_o), 32'd0);
    check("rst_mid_vld", 32'(resp_valid), 32'd0);
    check("rst_mid_rdy", 32'(req_ready), 32'd1);
    check("rst_mid_rd", 32'(resp_rd), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("post_rst_vld", 32'(resp_valid), 32'd0);
    check("post_rst_ld_o", 32'(data_o), 32'd0);
    check("post_rst_rdy", 32'(req_ready), 32'd1);
    @(negedge CLK);
    check("post_rst_vld2", 32'(resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that sits between the execute stage and the byte-addressed data memory and acts as the initiator of its store/load strobe interface. It accepts one memory request at a time from the pipeline, computes the effective address, and decodes RV32I funct3 into width and sign-extension controls. It checks alignment, range and encoding, drives a single-cycle store or load strobe, and returns a tagged response, absorbing the memory's one-cycle registered read latency.

## Interface
- MEM_BYTES, 4021: data memory size in bytes; the last valid byte address is MEM_BYTES-1.
- CLK  in  1  rising-edge clock shared with the data memory.
- RST_N  in  1  reset, asynchronous and active-low.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the instruction.
- req_base  in  32  rs1 value.
- req_offset  in  32  sign-extended immediate.
- req_wdata  in  32  rs2 value (store data).
- req_rd  in  5  destination tag, returned unchanged.
- data_addr  out  32  byte address to memory.
- data_width  out  2  00 word, 01 half, 10 byte.
- data_i  out  1  store strobe.
- data_o  out  1  load strobe.
- signext  out  1  sign-extend a sub-word load.
- input_data  out  32  store data to memory.
- read  in  32  registered memory read data.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  32  load result; 0 for stores and faults.
- resp_rd  out  5  tag of the request being responded to.
- resp_err  out  1  request faulted; no memory access occurred.
- resp_cause  out  2  00 none, 01 misaligned, 10 out of range, 11 illegal funct3.

## Operation
- Handshake: the request is accepted when req_valid && req_ready. All request fields and the effective address (req_base + req_offset, mod 2^32) are captured into registers.
- States: IDLE -> ISSUE (on accept) -> IDLE (store or fault) or -> RESP (load) -> IDLE.
- Decode from the captured funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Width: x00 -> 10 (byte), x01 -> 01 (half), x10 -> 00 (word). signext = ~funct3[2].
- Fault checks, in priority order:
  - illegal funct3 (load 011/110/111; store with funct3[2]=1) -> 11.
  - half with addr[0]=1, or word with addr[1:0]!=0 -> 01.
  - addr + bytes - 1 >= MEM_BYTES, computed at 33-bit width so wrap-around counts as out of range -> 10.
- ISSUE state:
  - No fault, store: data_i=1 for exactly this cycle, and resp_valid=1.
  - No fault, load: data_o=1 for exactly this cycle.
  - Fault: no strobe; resp_valid=1, resp_err=1, resp_cause set.
- RESP state: resp_valid=1, resp_data=read (combinational pass-through), resp_err=0.
- data_i and data_o are never high together, and never outside ISSUE.
- data_addr, data_width, signext and input_data are driven from the captured registers in every state. They are stable while a strobe is high.
- resp_rd always reflects the captured tag.

## Timing
- Reset (asynchronous, RST_N low) forces:
  - state IDLE; req_ready=1;
  - data_i=0, data_o=0, resp_valid=0, resp_err=0, resp_cause=00;
  - all captured registers 0, so data_addr, input_data, resp_data and resp_rd are 0, and data_width=00.
- Reset mid-ISSUE drops the strobe immediately. The request is lost and no response is produced.
- Store: accepted at edge N; data_i and resp_valid high in cycle N+1; memory written at the end of cycle N+1; req_ready high again in cycle N+2.
- Load: accepted at edge N; data_o high in cycle N+1; resp_valid with data in cycle N+2; req_ready high again in cycle N+3.
- Fault: resp_valid in cycle N+1; throughput is 1 request per 2 cycles.
- req_valid while busy is ignored, because req_ready=0. The pipeline holds its request.
- There is no back-pressure on the response; the consumer must take resp_valid in the cycle it is asserted.

## Structure
- Package dmem_lsu_pkg holds:
  - funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW);
  - width encodings (W_WORD=2'b00, W_HALF=2'b01, W_BYTE=2'b10);
  - state enum {IDLE, ISSUE, RESP};
  - cause codes.
- Sub-module dmem_lsu_check is purely combinational: it takes funct3, store and address, and produces width, signext, fault and cause. The FSM, capture registers and outputs stay in dmem_lsu.

## Test plan
- SW: base=0x100, offset=4, wdata=0xDEADBEEF -> in cycle N+1, data_i=1, data_addr=0x104, data_width=00, input_data=0xDEADBEEF, resp_valid=1, resp_err=0.
- LB after memory byte 0x104=0xEF -> data_o=1, data_width=10, signext=1 in N+1; memory is modelled as a sign-extending byte read, so read=0xFFFFFFEF, and resp_data=0xFFFFFFEF with resp_rd matching in N+2. LBU must give signext=0.
- LH at addr 0x103 -> resp_err=1, resp_cause=01 in N+1; data_i and data_o stay 0 throughout.
- LW at addr 4020 (MEM_BYTES=4021), and LW with base=0xFFFFFFFC, offset=8 -> both give resp_cause=10. LB at 4020 succeeds.
- Load with funct3=011, and store with funct3=100 -> resp_cause=11, no strobe.
- Back-to-back requests with req_valid held high -> accepts only on req_ready. Asserting RST_N=0 during ISSUE of a load drops data_o asynchronously, gives no resp_valid, and req_ready=1 after release.
